servo_pwm_decoder: RTL



---
 rtl/servo_pwm_decoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures servo PWM high time and converts it to a 9-degree step index
// Ports:
//   CLOCK_50  in   system clock
//   RESET_N   in   synchronous active-low reset
//   pwm_in    in   asynchronous PWM input
//   width     out  last accepted high time in clocks
//   angle_idx out  step index 0..MAX_STEP
//   angle_deg out  angle_idx*9
//   valid     out  one-cycle strobe, all result outputs updated
//   range_err out  last accepted pulse was out of range
//   lost      out  no rising edge for TIMEOUT clocks
module servo_pwm_decoder #(
    parameter int MIN_WIDTH  = 25000,
    parameter int STEP       = 5000,
    parameter int MAX_STEP   = 20,
    parameter int GLITCH_MIN = 50,
    parameter int TIMEOUT    = 1100000
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        pwm_in,
    output logic [17:0] width,
    output logic [4:0]  angle_idx,
    output logic [7:0]  angle_deg,
    output logic        valid,
    output logic        range_err,
    output logic        lost
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [18:0] LO_W    = 19'(MIN_WIDTH - STEP / 2);
    localparam logic [18:0] HI_W    = 19'(MIN_WIDTH + MAX_STEP * STEP + STEP / 2);
    localparam logic [18:0] MIN_W   = 19'(MIN_WIDTH);
    localparam logic [18:0] HALF_W  = 19'(STEP / 2);
    localparam logic [18:0] STEP_W  = 19'(STEP);
    localparam logic [17:0] GLIT_W  = 18'(GLITCH_MIN);
    localparam logic [17:0] CMAX    = '1;
    localparam logic [4:0]  LAST    = 5'(MAX_STEP);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {SYNC_WAIT, WAIT_RISE, HIGH, CONVERT} state_t;
    state_t state, state_n;

    logic s1, s2, prev, rise, fall;
    logic [17:0] cnt, w_lat;
    logic [18:0] r, cw;
    logic [4:0]  idx, idx_n, ccnt;
    logic        err, pend, ge, out_lo, out_hi;
    logic        load, run, strobe;
    logic [TW-1:0] tcnt, tcnt_n;

    assign rise   = s2 & ~prev;
    assign fall   = ~s2 & prev;
    assign cw     = {1'b0, cnt};
    assign out_lo = cw < LO_W;
    assign out_hi = cw >= HI_W;
    assign ge     = r >= STEP_W;
    assign idx_n  = idx + {4'b0, ge};
    assign tcnt_n = rise ? '0 : (tcnt == TMAX ? TMAX : tcnt + 1'b1);

    always_ff @(posedge CLOCK_50) begin
        state <= !RESET_N ? SYNC_WAIT : state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            SYNC_WAIT: state_n = s2 ? SYNC_WAIT : WAIT_RISE;
            WAIT_RISE: state_n = rise ? HIGH : WAIT_RISE;
            HIGH:      state_n = !fall ? HIGH : (cnt >= GLIT_W ? CONVERT : WAIT_RISE);
            CONVERT:   state_n = ccnt != LAST ? CONVERT : ((pend | rise) ? HIGH : WAIT_RISE);
        endcase
    end

    // The width counter also runs during CONVERT once a new rise has been seen,
    // so a pulse starting before the conversion ends is measured in full.
    always_comb begin
        load   = state == HIGH && fall && cnt >= GLIT_W;
        run    = state == HIGH || (state == CONVERT && pend);
        strobe = state == CONVERT && ccnt == LAST;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            // Synchronizer presets high so a pulse in progress at release is never seen as a rise.
            s1        <= 1'b1;
            s2        <= 1'b1;
            prev      <= 1'b1;
            cnt       <= '0;
            w_lat     <= '0;
            r         <= '0;
            idx       <= '0;
            ccnt      <= '0;
            err       <= 1'b0;
            pend      <= 1'b0;
            tcnt      <= '0;
            width     <= '0;
            angle_idx <= '0;
            angle_deg <= '0;
            valid     <= 1'b0;
            range_err <= 1'b0;
            lost      <= 1'b1;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            prev <= s2;
            cnt  <= rise ? 18'd1 : ((run && cnt != CMAX) ? cnt + 18'd1 : cnt);
            if (load) begin
                w_lat <= cnt;
                err   <= out_lo | out_hi;
                idx   <= out_hi ? LAST : 5'd0;
                r     <= (out_lo | out_hi) ? 19'd0 : cw - MIN_W + HALF_W;
                ccnt  <= '0;
                pend  <= 1'b0;
            end else if (state == CONVERT) begin
                r    <= ge ? r - STEP_W : r;
                idx  <= idx_n;
                ccnt <= ccnt + 5'd1;
                pend <= pend | rise;
            end
            if (strobe) begin
                width     <= w_lat;
                angle_idx <= idx_n;
                angle_deg <= {idx_n, 3'b000} + {3'b000, idx_n};
                range_err <= err;
            end
            valid <= strobe;
            tcnt  <= tcnt_n;
            lost  <= (tcnt_n == TMAX) ? 1'b1 : (strobe ? 1'b0 : lost);
        end
    end
endmodule
